// File: rtl/ddr2_pkg.sv
// Shared DDR2 definitions: command encodings, mode-register codes and the init FSM states.
package ddr2_pkg;

  localparam logic [2:0] CMD_NOP = 3'b111;
  localparam logic [2:0] CMD_PRE = 3'b010;
  localparam logic [2:0] CMD_REF = 3'b001;
  localparam logic [2:0] CMD_MRS = 3'b000;

  localparam logic [1:0] BA_MR   = 2'b00;
  localparam logic [1:0] BA_EMR1 = 2'b01;
  localparam logic [1:0] BA_EMR2 = 2'b10;
  localparam logic [1:0] BA_EMR3 = 2'b11;

  localparam logic [12:0] A_ZERO      = 13'h0000;
  localparam logic [12:0] A_PRE_ALL   = 13'h0400;
  localparam logic [12:0] A_MR_DLLRST = 13'h0742;
  localparam logic [12:0] A_MR_RUN    = 13'h0642;
  localparam logic [12:0] A_EMR1_OCD  = 13'h0380;

  typedef enum logic [3:0] {
    WAIT_INIT, CKE_UP, PRE_ALL1, EMR2, EMR3, EMR1_DLL, MR_DLLRST, PRE_ALL2,
    REF1, REF2, MR_RUN, EMR1_OCD, EMR1_EXIT, WAIT_DLL, DONE
  } init_state_e;

  typedef struct packed {
    logic        init_done;
    logic        cke;
    logic        csbar;
    logic [2:0]  rcw;
    logic [1:0]  ba;
    logic [12:0] a;
  } pin_word_t;

  localparam pin_word_t PINS_RESET = '{init_done: 1'b0, cke: 1'b0, csbar: 1'b1,
                                       rcw: CMD_NOP, ba: BA_MR, a: A_ZERO};

  function automatic int clamp_min(input int v, input int lo);
    return (v < lo) ? lo : v;
  endfunction

  function automatic int max_int(input int x, input int y);
    return (x > y) ? x : y;
  endfunction

endpackage

// File: rtl/ddr2_init_sequencer_if.sv
// SDRAM command pins plus init status, driven by the init sequencer.
interface ddr2_init_sequencer_if;
  logic        cke;
  logic        csbar;
  logic        rasbar;
  logic        casbar;
  logic        webar;
  logic [1:0]  ba;
  logic [12:0] a;
  logic        odt;
  logic        init_done;

  modport master (output cke, csbar, rasbar, casbar, webar, ba, a, odt, init_done);
  modport slave  (input  cke, csbar, rasbar, casbar, webar, ba, a, odt, init_done);
endinterface

// File: rtl/ddr2_wait_counter.sv
// Loadable down-counter; expired is high while the count sits at zero.
module ddr2_wait_counter #(
  parameter int W           = 8,
  parameter int RESET_VALUE = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         load,
  input  logic [W-1:0] value,
  output logic         expired
);

  logic [W-1:0] count;

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      count <= W'(RESET_VALUE);
    else if (load)
      count <= value;
    else if (count != '0)
      count <= count - W'(1);
  end

  assign expired = (count == '0);

endmodule

// File: rtl/ddr2_init_sequencer.sv
// DDR2 power-up init engine: drives the JEDEC init command sequence and flags init_done.
// state     | meaning
// WAIT_INIT | CKE low, deselect, T_INIT cycles
// CKE_UP    | CKE high, NOPs for T_CKE_NOP
// PRE_ALL*  | precharge all, wait T_RP
// EMR*/MR*  | mode register loads, wait T_MRD
// REF*      | auto refresh, wait T_RFC
// WAIT_DLL  | NOP until DLL lock time met
// DONE      | init_done, NOP forever
module ddr2_init_sequencer
  import ddr2_pkg::*;
#(
  parameter int T_INIT    = 53334,
  parameter int T_CKE_NOP = 107,
  parameter int T_RP      = 4,
  parameter int T_MRD     = 2,
  parameter int T_RFC     = 28,
  parameter int T_DLL     = 200
) (
  input logic clk,
  input logic reset,
  ddr2_init_sequencer_if.master pins
);

  localparam int INIT_C    = clamp_min(T_INIT, 1);
  localparam int CKE_NOP_C = clamp_min(T_CKE_NOP, 1);
  localparam int RP_C      = clamp_min(T_RP, 2);
  localparam int MRD_C     = clamp_min(T_MRD, 2);
  localparam int RFC_C     = clamp_min(T_RFC, 2);
  localparam int DLL_C     = clamp_min(T_DLL, 1);
  // Counter sized for the largest interval so small T_INIT overrides cannot truncate other waits.
  localparam int CNT_MAX   = max_int(max_int(INIT_C, CKE_NOP_C), max_int(RP_C, max_int(MRD_C, RFC_C)));
  localparam int CNT_W     = $clog2(CNT_MAX + 1);
  localparam int DLL_W     = $clog2(DLL_C + 1);

  init_state_e      state, state_next;
  logic             load_cnt, expired;
  logic [CNT_W-1:0] load_value;
  int               wait_len;
  logic             dll_run, dll_ready;
  logic [DLL_W-1:0] dll_cnt;
  pin_word_t        pins_q, pins_next;

  ddr2_wait_counter #(.W(CNT_W), .RESET_VALUE(INIT_C - 1)) u_wait (
    .clk     (clk),
    .reset   (reset),
    .load    (load_cnt),
    .value   (load_value),
    .expired (expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      state <= WAIT_INIT;
    else
      state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      WAIT_INIT: if (expired) state_next = CKE_UP;
      CKE_UP:    if (expired) state_next = PRE_ALL1;
      PRE_ALL1:  if (expired) state_next = EMR2;
      EMR2:      if (expired) state_next = EMR3;
      EMR3:      if (expired) state_next = EMR1_DLL;
      EMR1_DLL:  if (expired) state_next = MR_DLLRST;
      MR_DLLRST: if (expired) state_next = PRE_ALL2;
      PRE_ALL2:  if (expired) state_next = REF1;
      REF1:      if (expired) state_next = REF2;
      REF2:      if (expired) state_next = MR_RUN;
      MR_RUN:    if (expired) state_next = EMR1_OCD;
      EMR1_OCD:  if (expired) state_next = EMR1_EXIT;
      EMR1_EXIT: if (expired) state_next = dll_ready ? DONE : WAIT_DLL;
      WAIT_DLL:  if (dll_ready) state_next = DONE;
      DONE:      state_next = DONE;
      default:   state_next = WAIT_INIT;
    endcase
  end

  // Every state entry issues its command and restarts the spacing timer.
  assign load_cnt = (state_next != state);

  always_comb begin
    wait_len = 1;
    case (state_next)
      CKE_UP:                 wait_len = CKE_NOP_C;
      PRE_ALL1, PRE_ALL2:     wait_len = RP_C;
      REF1, REF2:             wait_len = RFC_C;
      EMR2, EMR3, EMR1_DLL, MR_DLLRST,
      MR_RUN, EMR1_OCD, EMR1_EXIT: wait_len = MRD_C;
      default:                wait_len = 1;
    endcase
  end

  assign load_value = CNT_W'(wait_len - 1);

  // DLL lock timer: starts with MR_DLLRST, saturates, cleared only by reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dll_run <= 1'b0;
      dll_cnt <= '0;
    end else begin
      if (state_next == MR_DLLRST)
        dll_run <= 1'b1;
      if (dll_run && (dll_cnt != DLL_W'(DLL_C)))
        dll_cnt <= dll_cnt + DLL_W'(1);
    end
  end

  assign dll_ready = dll_run && (dll_cnt >= DLL_W'(DLL_C - 1));

  always_comb begin
    pins_next = '{init_done: 1'b0, cke: 1'b1, csbar: 1'b0, rcw: CMD_NOP, ba: BA_MR, a: A_ZERO};
    case (state_next)
      WAIT_INIT: begin
        pins_next.cke   = 1'b0;
        pins_next.csbar = 1'b1;
      end
      DONE: pins_next.init_done = 1'b1;
      default: begin
        if (load_cnt) begin
          case (state_next)
            PRE_ALL1, PRE_ALL2: begin pins_next.rcw = CMD_PRE; pins_next.a = A_PRE_ALL; end
            EMR2:      begin pins_next.rcw = CMD_MRS; pins_next.ba = BA_EMR2; end
            EMR3:      begin pins_next.rcw = CMD_MRS; pins_next.ba = BA_EMR3; end
            EMR1_DLL:  begin pins_next.rcw = CMD_MRS; pins_next.ba = BA_EMR1; end
            MR_DLLRST: begin pins_next.rcw = CMD_MRS; pins_next.a = A_MR_DLLRST; end
            REF1, REF2: pins_next.rcw = CMD_REF;
            MR_RUN:    begin pins_next.rcw = CMD_MRS; pins_next.a = A_MR_RUN; end
            EMR1_OCD:  begin pins_next.rcw = CMD_MRS; pins_next.ba = BA_EMR1; pins_next.a = A_EMR1_OCD; end
            EMR1_EXIT: begin pins_next.rcw = CMD_MRS; pins_next.ba = BA_EMR1; end
            default:   pins_next.rcw = CMD_NOP;
          endcase
        end
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)
      pins_q <= PINS_RESET;
    else
      pins_q <= pins_next;
  end

  assign pins.cke       = pins_q.cke;
  assign pins.csbar     = pins_q.csbar;
  assign pins.rasbar    = pins_q.rcw[2];
  assign pins.casbar    = pins_q.rcw[1];
  assign pins.webar     = pins_q.rcw[0];
  assign pins.ba        = pins_q.ba;
  assign pins.a         = pins_q.a;
  assign pins.odt       = 1'b0;
  assign pins.init_done = pins_q.init_done;

endmodule

// File: tb/tb_ddr2_init_sequencer.sv
// Bench for ddr2_init_sequencer: two parameter sets, per-cycle reference model, random mid-sequence resets.
module tb_ddr2_init_sequencer;

  typedef struct {
    int t_init; int t_cke_nop; int t_rp; int t_mrd; int t_rfc; int t_dll;
  } cfg_t;

  typedef struct {
    logic [2:0]  rcw;
    logic [1:0]  ba;
    logic [12:0] a;
    int          gap_kind;   // 0 T_RP, 1 T_MRD, 2 T_RFC, 3 last command
  } cmd_rec_t;

  typedef struct {
    int          cyc;
    logic [2:0]  rcw;
    logic [1:0]  ba;
    logic [12:0] a;
  } obs_t;

  // {init_done, cke, csbar, ras, cas, we, ba, a, odt}
  localparam logic [21:0] RESET_VEC = {1'b0, 1'b0, 1'b1, 3'b111, 2'b00, 13'h0000, 1'b0};

  logic clk = 1'b0;
  logic rst_a, rst_b;
  always #5 clk = ~clk;

  ddr2_init_sequencer_if pins_a ();
  ddr2_init_sequencer_if pins_b ();

  ddr2_init_sequencer #(.T_INIT(10)) dut_a (
    .clk (clk), .reset (rst_a), .pins (pins_a)
  );

  ddr2_init_sequencer #(.T_INIT(7), .T_CKE_NOP(5), .T_RP(3), .T_MRD(1), .T_RFC(6), .T_DLL(2)) dut_b (
    .clk (clk), .reset (rst_b), .pins (pins_b)
  );

  cmd_rec_t tab [11];
  cfg_t     cfg_a, cfg_b;
  obs_t     obs_a [$];
  obs_t     obs_b [$];
  int       n_tests = 0;
  int       n_fail  = 0;

  function automatic int sp(input int v);
    return (v < 2) ? 2 : v;
  endfunction

  function automatic int gap_of(input cfg_t c, input int kind);
    case (kind)
      0:       return sp(c.t_rp);
      1:       return sp(c.t_mrd);
      2:       return sp(c.t_rfc);
      default: return 0;
    endcase
  endfunction

  // Expected pins after rising edge k (k counted from reset release).
  function automatic logic [21:0] exp_vec(input cfg_t c, input int k);
    logic [21:0] v;
    int t, t_mr, t_exit, done;
    if (k < c.t_init) return RESET_VEC;
    v = {1'b0, 1'b1, 1'b0, 3'b111, 2'b00, 13'h0000, 1'b0};
    t = c.t_init + c.t_cke_nop;
    t_mr = 0;
    t_exit = 0;
    for (int i = 0; i < 11; i++) begin
      if (k == t) v = {1'b0, 1'b1, 1'b0, tab[i].rcw, tab[i].ba, tab[i].a, 1'b0};
      if (i == 4) t_mr = t;
      if (i == 10) t_exit = t;
      else t += gap_of(c, tab[i].gap_kind);
    end
    done = (t_exit + sp(c.t_mrd) > t_mr + c.t_dll) ? t_exit + sp(c.t_mrd) : t_mr + c.t_dll;
    if (k >= done) v[21] = 1'b1;
    return v;
  endfunction

  function automatic logic [21:0] vec_a();
    return {pins_a.init_done, pins_a.cke, pins_a.csbar, pins_a.rasbar, pins_a.casbar,
            pins_a.webar, pins_a.ba, pins_a.a, pins_a.odt};
  endfunction

  function automatic logic [21:0] vec_b();
    return {pins_b.init_done, pins_b.cke, pins_b.csbar, pins_b.rasbar, pins_b.casbar,
            pins_b.webar, pins_b.ba, pins_b.a, pins_b.odt};
  endfunction

  task automatic check_vec(input string name, input int k, input logic [21:0] act, input logic [21:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, k, act, exp);
    end
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_tests++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  initial begin
    int ka, kb, abort_a, abort_b;
    int cke_rise_a, done_a, done_b;

    tab[0]  = '{3'b010, 2'b00, 13'h0400, 0};
    tab[1]  = '{3'b000, 2'b10, 13'h0000, 1};
    tab[2]  = '{3'b000, 2'b11, 13'h0000, 1};
    tab[3]  = '{3'b000, 2'b01, 13'h0000, 1};
    tab[4]  = '{3'b000, 2'b00, 13'h0742, 1};
    tab[5]  = '{3'b010, 2'b00, 13'h0400, 0};
    tab[6]  = '{3'b001, 2'b00, 13'h0000, 2};
    tab[7]  = '{3'b001, 2'b00, 13'h0000, 2};
    tab[8]  = '{3'b000, 2'b00, 13'h0642, 1};
    tab[9]  = '{3'b000, 2'b01, 13'h0380, 1};
    tab[10] = '{3'b000, 2'b01, 13'h0000, 3};
    cfg_a = '{10, 107, 4, 2, 28, 200};
    cfg_b = '{7, 5, 3, 1, 6, 2};

    cke_rise_a = -1;
    done_a = -1;
    done_b = -1;
    // Phase 2 resets land inside the REF1 wait of each instance.
    abort_a = 1352 + 133 + int'($urandom_range(1, 27));
    abort_b = 1352 + 26 + int'($urandom_range(1, 5));

    rst_a = 1'b1;
    rst_b = 1'b1;
    #12;
    check_vec("reset_a", 0, vec_a(), RESET_VEC);
    check_vec("reset_b", 0, vec_b(), RESET_VEC);
    @(negedge clk);
    rst_a = 1'b0;
    rst_b = 1'b0;
    ka = 0;
    kb = 0;

    for (int cyc = 1; cyc <= 2000; cyc++) begin
      @(posedge clk);
      #1;
      if (ka >= 0) ka++;
      if (kb >= 0) kb++;
      check_vec("seq_a", ka, vec_a(), (ka < 0) ? RESET_VEC : exp_vec(cfg_a, ka));
      check_vec("seq_b", kb, vec_b(), (kb < 0) ? RESET_VEC : exp_vec(cfg_b, kb));
      if (cyc <= 1350) begin
        if (cke_rise_a < 0 && pins_a.cke) cke_rise_a = ka;
        if (done_a < 0 && pins_a.init_done) done_a = ka;
        if (done_b < 0 && pins_b.init_done) done_b = kb;
        if (!pins_a.csbar && {pins_a.rasbar, pins_a.casbar, pins_a.webar} != 3'b111)
          obs_a.push_back('{ka, {pins_a.rasbar, pins_a.casbar, pins_a.webar}, pins_a.ba, pins_a.a});
        if (!pins_b.csbar && {pins_b.rasbar, pins_b.casbar, pins_b.webar} != 3'b111)
          obs_b.push_back('{kb, {pins_b.rasbar, pins_b.casbar, pins_b.webar}, pins_b.ba, pins_b.a});
      end
      #2;
      if (cyc == 1350 || cyc == abort_a) rst_a = 1'b1;
      if (cyc == 1350 || cyc == abort_b) rst_b = 1'b1;
      #1;
      if (rst_a && ka >= 0) begin
        check_vec("async_reset_a", ka, vec_a(), RESET_VEC);
        ka = -1;
      end
      if (rst_b && kb >= 0) begin
        check_vec("async_reset_b", kb, vec_b(), RESET_VEC);
        kb = -1;
      end
      #1;
      if (cyc == 1352 || cyc == abort_a + 2) begin rst_a = 1'b0; ka = 0; end
      if (cyc == 1352 || cyc == abort_b + 2) begin rst_b = 1'b0; kb = 0; end
    end

    check_int("cke_rise_cycle_a", cke_rise_a, 10);
    check_int("init_done_cycle_a", done_a, 327);
    check_int("init_done_cycle_b", done_b, 44);
    check_int("cmd_count_a", obs_a.size(), 11);
    check_int("cmd_count_b", obs_b.size(), 11);
    if (obs_a.size() > 0) check_int("first_pre_cycle_a", obs_a[0].cyc, 117);
    if (obs_a.size() > 4) check_int("dll_to_done_a", done_a - obs_a[4].cyc, 200);
    if (obs_b.size() > 10) check_int("exit_to_done_b", done_b - obs_b[10].cyc, 2);
    if (obs_b.size() > 2) check_int("mrs_spacing_b", obs_b[2].cyc - obs_b[1].cyc, 2);

    for (int i = 0; i < 11 && i < obs_a.size(); i++) begin
      check_int($sformatf("order_a_cmd%0d_op", i), int'(obs_a[i].rcw), int'(tab[i].rcw));
      check_int($sformatf("order_a_cmd%0d_ba", i), int'(obs_a[i].ba), int'(tab[i].ba));
      check_int($sformatf("order_a_cmd%0d_a", i), int'(obs_a[i].a), int'(tab[i].a));
      if (i > 0)
        check_int($sformatf("gap_a_cmd%0d", i), obs_a[i].cyc - obs_a[i-1].cyc, gap_of(cfg_a, tab[i-1].gap_kind));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
